// File: rtl/progsel_pkg.sv
// Shared types and constants for the program launcher.
// Optional debounce counters are enabled with PROGSEL_DEBOUNCE_EN.
package progsel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } progsel_state_e;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [1:0] ST_GAP    = GAP;

  // Button i launches program code i + CODE_OFFSET; code 0 means "no program".
  localparam int CODE_OFFSET = 1;

  // Width of a counter that must hold values 0..max_count (never narrower than 1 bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/progsel_debounce.sv
// One button: 2-flop synchroniser, optional debounce (PROGSEL_DEBOUNCE_EN),
// debounced level register and rising-edge detect producing a one-cycle press pulse.
module progsel_debounce
  import progsel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic level_r;
  logic level_prev_r;

  // Synchronise the raw asynchronous button level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

`ifdef PROGSEL_DEBOUNCE_EN
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_r;

  // Flip the level only after a long enough run of disagreeing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (sync2_r != level_r) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r   <= '0;
        level_r <= ~level_r;
      end else begin
        cnt_r   <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end
`else
  // Without debounce the level is simply the synchronised input, registered once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_r <= 1'b0;
    end else begin
      level_r <= sync2_r;
    end
  end
`endif

  // Delayed copy of the level for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_prev_r <= 1'b0;
    end else begin
      level_prev_r <= level_r;
    end
  end

  assign press = level_r & ~level_prev_r;

endmodule

// File: rtl/progsel_launcher.sv
// Program launcher top: per-button conditioning, fixed-priority arbiter,
// one-deep pending register and IDLE/ACTIVE/GAP selector FSM. Debounce via PROGSEL_DEBOUNCE_EN.
module progsel_launcher
  import progsel_pkg::*;
#(
  parameter int NUM_BTNS        = 4,
  parameter int SEL_W           = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HOLD        = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic                ack,
  output logic [SEL_W-1:0]    program_selector,
  output logic                busy,
  output logic                pending_valid,
  output logic                dropped
);

  localparam int HOLD_W = cnt_width(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);

  logic [NUM_BTNS-1:0] req_s;
  logic                win_found_s;
  logic                lose_s;
  logic [SEL_W-1:0]    win_code_s;

  logic [1:0]          state_r, state_n;
  logic [SEL_W-1:0]    selector_r, selector_n;
  logic [HOLD_W-1:0]   hold_r, hold_n;
  logic                pend_v_r, pend_v_n;
  logic [SEL_W-1:0]    pend_code_r, pend_code_n;
  logic                dropped_r, dropped_n;
  logic                busy_r;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    progsel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock(clock),
      .reset(reset),
      .btn  (btn[g]),
      .press(req_s[g])
    );
  end

  // Fixed priority: lowest index wins, any other simultaneous press is a loser.
  always_comb begin
    win_found_s = 1'b0;
    lose_s      = 1'b0;
    win_code_s  = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (req_s[i] && win_found_s) begin
        lose_s = 1'b1;
      end else if (req_s[i]) begin
        win_found_s = 1'b1;
        win_code_s  = SEL_W'(i + CODE_OFFSET);
      end else begin
        lose_s = lose_s;
      end
    end
  end

  // Next-state logic: a queued code always launches before a fresh request,
  // and a fresh request arriving as the queue drains refills it.
  always_comb begin
    state_n     = state_r;
    selector_n  = selector_r;
    hold_n      = hold_r;
    pend_v_n    = pend_v_r;
    pend_code_n = pend_code_r;
    dropped_n   = lose_s;
    case (state_r)
      ST_IDLE: begin
        if (pend_v_r) begin
          state_n     = ST_ACTIVE;
          selector_n  = pend_code_r;
          hold_n      = '0;
          pend_v_n    = win_found_s;
          pend_code_n = win_code_s;
        end else if (win_found_s) begin
          state_n    = ST_ACTIVE;
          selector_n = win_code_s;
          hold_n     = '0;
        end else begin
          selector_n = '0;
        end
      end
      ST_ACTIVE: begin
        if (hold_r != HOLD_MAX) begin
          hold_n = hold_r + HOLD_W'(1);
        end else begin
          hold_n = hold_r;
        end
        if (ack && (hold_r >= HOLD_LAST)) begin
          state_n    = ST_GAP;
          selector_n = '0;
        end else begin
          selector_n = selector_r;
        end
        if (win_found_s && !pend_v_r) begin
          pend_v_n    = 1'b1;
          pend_code_n = win_code_s;
        end else if (win_found_s) begin
          dropped_n = 1'b1;
        end else begin
          dropped_n = lose_s;
        end
      end
      ST_GAP: begin
        if (pend_v_r) begin
          state_n    = ST_ACTIVE;
          selector_n = pend_code_r;
          hold_n     = '0;
        end else begin
          state_n    = ST_IDLE;
          selector_n = '0;
        end
        pend_v_n    = win_found_s;
        pend_code_n = win_code_s;
      end
      default: begin
        state_n     = ST_IDLE;
        selector_n  = '0;
        hold_n      = '0;
        pend_v_n    = 1'b0;
        pend_code_n = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      selector_r  <= '0;
      hold_r      <= '0;
      pend_v_r    <= 1'b0;
      pend_code_r <= '0;
      dropped_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      selector_r  <= selector_n;
      hold_r      <= hold_n;
      pend_v_r    <= pend_v_n;
      pend_code_r <= pend_code_n;
      dropped_r   <= dropped_n;
      busy_r      <= (state_n != ST_IDLE);
    end
  end

  assign program_selector = selector_r;
  assign busy             = busy_r;
  assign pending_valid    = pend_v_r;
  assign dropped          = dropped_r;

endmodule

// File: doc/progsel_launcher.md
# progsel_launcher

Parametrised program launcher. It turns NUM_BTNS raw push-button inputs into a registered program code that drives the processor's register-file program-select input. Each button is synchronised, optionally debounced, and edge-detected, then arbitrated by fixed priority. The selected code is held until the processor acknowledges it, and one further request can be queued. The block sits between the board buttons and the regfile, and its outputs also feed the labkit status display.

## Interface
Parameters:
- NUM_BTNS, 4: number of program buttons. Button i launches program code i+1.
- SEL_W, 32: width of program_selector. Must satisfy 2^SEL_W > NUM_BTNS.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a level change. Minimum 1.
- MIN_HOLD, 2: minimum cycles program_selector stays non-zero. Minimum 1.

Ports:
- clock, input, 1: the single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high. Clears all state immediately.
- btn, input, NUM_BTNS: raw, asynchronous button levels.
- ack, input, 1: processor has copied the selector. Level, sampled each cycle.
- program_selector, output, SEL_W: 0 = no program; otherwise the active code. Registered.
- busy, output, 1: high whenever the FSM is not IDLE. Registered.
- pending_valid, output, 1: a queued request exists. Registered.
- dropped, output, 1: one-cycle pulse when a request is discarded. Registered.

## Operation
- Per button: 2-flop synchroniser, then debounce (see Configuration), then a debounced level register, then rising-edge detect. The edge detect produces a one-cycle request pulse.
- Falling edges produce nothing.
- Arbitration: if several pulses occur in the same cycle, the lowest index wins. The losing pulses assert dropped for that cycle.
- FSM states:
  - IDLE: selector = 0. A request loads its code and the FSM enters ACTIVE.
  - ACTIVE: selector = code, and a hold counter increments. The FSM exits to GAP on the first cycle where ack = 1 and the counter ≥ MIN_HOLD−1. ack is ignored before that point.
  - GAP: selector = 0 for exactly one cycle. Next state is ACTIVE with the pending code (which clears pending_valid) if one exists, otherwise IDLE.
- Requests arriving while in ACTIVE or GAP go to the one-deep pending register if it is empty; otherwise they are dropped.
- If a new request and pending consumption fall in the same GAP cycle, the old pending entry launches and the new request refills pending.
- Reset asserted mid-operation: selector, busy, pending_valid, dropped, FSM, counters and debounced levels all go to 0 asynchronously.
- A button held through reset deassertion is treated as a new press and generates a request after the normal latency.

## Timing
- Reset values: program_selector = 0, busy = 0, pending_valid = 0, dropped = 0, FSM = IDLE.
- Latency: btn first sampled high at edge k and held thereafter. program_selector changes to code at edge k+3+DEBOUNCE_CYCLES with the macro defined, and at edge k+3 without it.
- dropped asserts at the same edge at which the losing request would otherwise have been registered.
- Shortest ACTIVE period: MIN_HOLD cycles. Between two consecutive codes there is always at least one cycle of selector = 0.
- busy rises with the selector's first non-zero edge and falls on the edge the FSM enters IDLE.

## Configuration
- PROGSEL_DEBOUNCE_EN defined: a per-button counter counts consecutive cycles in which the synchronised input differs from the debounced level. When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears. Any agreeing cycle also clears the counter.
- PROGSEL_DEBOUNCE_EN undefined: the debounced level is the synchronised input registered once. No counters are built and DEBOUNCE_CYCLES is ignored. This is the simulation/bench-speed build.

## Structure
- progsel_pkg contains:
  - the FSM state enum (IDLE, ACTIVE, GAP);
  - a localparam helper for the hold-counter width, $clog2(MIN_HOLD+1);
  - the code mapping constant CODE_OFFSET = 1.
- One sub-module, progsel_debounce: synchroniser + debounce + level register + edge detect for one button, instantiated NUM_BTNS times in a generate loop.
- The top level contains the arbiter, the pending register and the FSM.

## Test plan
- **Single press:** macro on, DEBOUNCE_CYCLES = 4, btn[0] held for 20 cycles, ack tied high. Expect program_selector = 1 from edge k+7 for exactly MIN_HOLD = 2 cycles, then 0, then busy = 0.
- **Bounce rejection:** btn[1] toggles every 2 cycles for 12 cycles, then settles high. Expect exactly one code 2 launch, with no launch during the toggling.
- **Simultaneous press:** btn[3] and btn[1] rise in the same cycle. Expect code 2 launched and a one-cycle dropped pulse.
- **Pending queue:** hold ack low, press btn[0], then btn[2], then btn[3]. Expect the selector to hold 1 and pending_valid = 1 after btn[2], and dropped after btn[3]. Raise ack: expect 1, then a GAP cycle with 0, then 3, then pending_valid = 0.
- **Reset mid-ACTIVE:** with selector = 2 and pending_valid = 1, assert reset between clock edges. Expect all outputs to go to 0 without waiting for a clock edge. With btn[1] still held at release, expect code 2 again after the latency.
- **Macro off:** same stimulus as the single-press scenario. Expect program_selector = 1 at edge k+3, and no debounce counters in the netlist.
